// File: rtl/mist_console_fifo_pkg.sv
// rtl/mist_console_fifo_pkg.sv - shared constants for the console receive FIFO
// Purpose: default depth, byte width and the occupancy counter width helper.
// Ports: none (package).
package mist_console_fifo_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 4;
  localparam int BYTE_W             = 8;

  // Occupancy runs 0..2**depth_log2 inclusive, so it needs one extra bit.
  function automatic int count_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/mist_console_fifo_mem.sv
// rtl/mist_console_fifo_mem.sv - unreset dual-port byte array for the console FIFO
// Purpose: storage with synchronous write and asynchronous read.
// Ports:
//   clk          - write clock
//   we           - write enable
//   waddr, wdata - write address / byte
//   raddr        - read address (read pointer)
//   rdata        - combinational read of raddr
module mist_console_fifo_mem
  import mist_console_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [BYTE_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [BYTE_W-1:0]     rdata
);

  logic [BYTE_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mist_console_fifo.sv
// rtl/mist_console_fifo.sv - first-word fall-through FIFO for console receiver bytes
// Purpose: buffers bytes from a level-style byte-valid strobe for the IO controller.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   in_data    - received byte
//   in_strobe  - receiver byte-valid level; its rising edge pushes in_data
//   rd_req     - single-cycle pop request
//   ovf_clr    - clears the sticky overflow flag
//   out_data   - head byte (valid when out_valid)
//   out_valid  - FIFO not empty
//   count      - occupancy 0..2**DEPTH_LOG2
//   overflow   - sticky flag: a byte was dropped because the FIFO was full
module mist_console_fifo
  import mist_console_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [BYTE_W-1:0]                   in_data,
  input  logic                                in_strobe,
  input  logic                                rd_req,
  input  logic                                ovf_clr,
  output logic [BYTE_W-1:0]                   out_data,
  output logic                                out_valid,
  output logic [count_width(DEPTH_LOG2)-1:0]  count,
  output logic                                overflow
);

  localparam int CW = count_width(DEPTH_LOG2);
  localparam logic [CW-1:0] FULL_COUNT = CW'(2**DEPTH_LOG2);

  logic                  strobe_q;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  ovf_event;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign push_req = in_strobe & ~strobe_q;
  assign pop      = rd_req & ~empty;
  // A pop in the same cycle frees the slot, so a push while full is still taken.
  assign push      = push_req & (~full | pop);
  assign ovf_event = push_req & full & ~pop;

  assign out_valid = ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      strobe_q <= in_strobe;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // Set has priority over clear so a drop in the clearing cycle is not lost.
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  mist_console_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_mist_console_fifo.sv
// tb/tb_mist_console_fifo.sv - scoreboard bench for the console receive FIFO
module tb_mist_console_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_strobe;
  logic       rd_req;
  logic       ovf_clr;
  logic [7:0] out_data;
  logic       out_valid;
  logic [4:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mist_console_fifo #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .rd_req    (rd_req),
    .ovf_clr   (ovf_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .count     (count),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && rd_req && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected nothing", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    in_data   = b;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
    tick();
    if (accept) exp_q.push_back(b);
  endtask

  task automatic pop_one();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = 8'h00; in_strobe = 1'b0; rd_req = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("reset_count", count, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_ovf", overflow, 0);
    reset = 1'b0;
    tick();

    // Held strobe level gives exactly one push.
    in_data = 8'h41; in_strobe = 1'b1;
    tick();
    chk("edge_count", count, 1);
    chk("edge_data", out_data, 8'h41);
    repeat (49) tick();
    chk("edge_hold_count", count, 1);
    in_strobe = 1'b0;
    tick();
    exp_q.push_back(8'h41);
    pop_one();
    chk("edge_drain_count", count, 0);

    // Ordering.
    push_byte(8'h10, 1); push_byte(8'h20, 1); push_byte(8'h30, 1);
    chk("order_count", count, 3);
    repeat (3) pop_one();
    chk("order_valid", out_valid, 0);
    chk("order_count0", count, 0);

    // Overflow on the 17th byte.
    for (int i = 0; i < 17; i++) push_byte(8'(i), i < 16);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_data, 8'h00);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Clear and new drop in the same cycle: set wins.
    in_data = 8'h11; in_strobe = 1'b1; ovf_clr = 1'b1;
    tick();
    in_strobe = 1'b0; ovf_clr = 1'b0;
    tick();
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_set_wins_count", count, 16);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr2", overflow, 0);

    // Full with simultaneous push and pop.
    in_data = 8'hAA; in_strobe = 1'b1; rd_req = 1'b1;
    tick();
    in_strobe = 1'b0; rd_req = 1'b0;
    exp_q.push_back(8'hAA);
    tick();
    chk("full_sim_count", count, 16);
    chk("full_sim_ovf", overflow, 0);
    repeat (16) pop_one();
    chk("full_drain_count", count, 0);

    // Empty with simultaneous push and pop: push only.
    in_data = 8'h55; in_strobe = 1'b1; rd_req = 1'b1;
    tick();
    in_strobe = 1'b0; rd_req = 1'b0;
    exp_q.push_back(8'h55);
    tick();
    chk("empty_sim_count", count, 1);
    chk("empty_sim_data", out_data, 8'h55);
    pop_one();
    chk("empty_sim_drain", count, 0);

    // Reset mid-run discards buffered bytes.
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1);
    chk("mid_count", count, 5);
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    push_byte(8'h77, 1);
    chk("post_rst_count", count, 1);
    pop_one();

    // Strobe already high when reset releases is pushed once.
    in_data = 8'h99; in_strobe = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rel_push_count", count, 1);
    repeat (5) tick();
    chk("rel_hold_count", count, 1);
    in_strobe = 1'b0;
    exp_q.push_back(8'h99);
    tick();
    pop_one();
    chk("rel_drain_count", count, 0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mist_console_fifo.md
MIST_CONSOLE_FIFO -- requirements
Module: mist_console_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, SHALL set storage depth to 2**DEPTH_LOG2 bytes (16 by default).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 Port in_data, input, 8 bits, SHALL carry the byte from the console serial receiver.
REQ-005 Port in_strobe, input, 1 bit, SHALL be the receiver's byte-valid level: high from byte completion until the next start bit.
REQ-006 Port rd_req, input, 1 bit, SHALL be the single-cycle pop request from the IO controller.
REQ-007 Port ovf_clr, input, 1 bit, SHALL clear the overflow flag.
REQ-008 Port out_data, output, 8 bits, SHALL present the head byte (first-word fall-through).
REQ-009 Port out_valid, output, 1 bit, SHALL be high when the FIFO is not empty.
REQ-010 Port count, output, DEPTH_LOG2+1 bits, SHALL give the current occupancy, 0..2**DEPTH_LOG2.
REQ-011 Port overflow, output, 1 bit, SHALL be a sticky flag for a dropped byte.

Function
REQ-012 Push SHALL be edge-triggered: a register holds the previous-cycle in_strobe value, and a push occurs in the cycle where in_strobe=1 and that register=0.
REQ-013 A level held high on in_strobe for any number of cycles SHALL produce exactly one push.
REQ-014 The pushed byte SHALL be the value of in_data in the push cycle.
REQ-015 out_valid and the new count SHALL be visible one cycle after the push cycle.
REQ-016 rd_req=1 with out_valid=1 SHALL pop the head; out_data SHALL show the next byte (or be don't-care if empty) the following cycle.
REQ-017 rd_req with the FIFO empty SHALL be ignored, with no pointer or count change.
REQ-018 A push while full without a simultaneous pop SHALL drop the byte, leave contents unchanged, and set overflow the next cycle.
REQ-019 A simultaneous push and pop while full SHALL perform both; count SHALL be unchanged and overflow SHALL NOT be set.
REQ-020 A simultaneous push and pop while empty SHALL perform the push only; count SHALL become 1.
REQ-021 A simultaneous push and pop in any other state SHALL leave count unchanged.
REQ-022 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth.
REQ-023 count SHALL be maintained separately: +1 on push-only, -1 on pop-only.
REQ-024 overflow SHALL stay set until ovf_clr=1.
REQ-025 If ovf_clr and a new overflow event occur in the same cycle, overflow SHALL end set (set wins).
REQ-026 Bytes SHALL be delivered in arrival order with no duplication.

Reset
REQ-027 While reset=1, pointers, count, overflow and the strobe history register SHALL be cleared to 0, and out_valid SHALL be 0.
REQ-028 Storage contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-029 The strobe history register SHALL clear to 0, so an in_strobe already high when reset releases is pushed once in the first post-reset cycle.
REQ-030 A reset asserted mid-operation SHALL discard all buffered bytes within one cycle.

Structure
REQ-031 A shared package SHALL hold the default DEPTH_LOG2, the byte width constant (8) and the count width expression.
REQ-032 Storage SHALL be one sub-module, mist_console_fifo_mem: a simple dual-port array with synchronous write and asynchronous read at the read pointer, with no reset.
REQ-033 Edge detection, pointers, count and overflow logic SHALL reside in mist_console_fifo.

Verification
REQ-034 Strobe edge: in_data=0x41 with in_strobe held high for 50 cycles -> count=1 and out_data=0x41 after one cycle, and count stays 1.
REQ-035 Order: push 0x10,0x20,0x30, then pulse rd_req three times -> out_data reads 0x10,0x20,0x30, then out_valid=0 and count=0.
REQ-036 Overflow: push 17 distinct bytes 0x00..0x10 -> count=16, overflow=1, head=0x00, and 0x10 never appears; ovf_clr pulse -> overflow=0.
REQ-037 Full plus simultaneous: FIFO full, push 0xAA in the same cycle as rd_req -> count=16, overflow=0, and 0xAA is the 16th byte read.
REQ-038 Empty plus simultaneous: FIFO empty, push 0x55 in the same cycle as rd_req -> count=1, out_data=0x55.
REQ-039 Reset mid-run: 5 bytes buffered, reset for one cycle -> count=0, out_valid=0, overflow=0; the next edge of 0x77 is read as 0x77.
